demux21_tdm: RTL and testbench
==============================

# demux21_tdm

Registered 1-to-2 time-division demultiplexer: the receiving end of the 2:1 channel mux path. Each valid input word on `Y` is routed by the accompanying select `S1` to channel register `D0` or `D1`. A two-state frame tracker checks strict channel-0-then-channel-1 ordering, pulses `FRAME` when a complete pair has arrived, and flags ordering errors. It sits downstream of a mux21-driven shared link and feeds per-channel consumers.

## Interface
Parameters:
- `WIDTH`, 8: data word width.
- `CNT_W`, 8: width of the frame counter and, when enabled, the error counter.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `VALID`  in  1  `Y`/`S1` carry a word this cycle.
- `S1`  in  1  channel select: 0 = channel 0, 1 = channel 1.
- `Y`  in  WIDTH  multiplexed data word.
- `D0`  out  WIDTH  channel-0 holding register.
- `D1`  out  WIDTH  channel-1 holding register.
- `V0`  out  1  one-cycle strobe: `D0` updated.
- `V1`  out  1  one-cycle strobe: `D1` updated.
- `FRAME`  out  1  one-cycle strobe: in-order ch0+ch1 pair completed.
- `FRAME_CNT`  out  CNT_W  completed-frame count.
- `ERR`  out  1  one-cycle strobe: ordering violation.
- `ERR_CNT`  out  CNT_W  error count. Present only with `DEMUX21_ERRCNT_EN`.

## Operation
- Reset (asserted at any time, effective immediately):
  - Outputs: `D0`, `D1`, `FRAME_CNT`, `ERR_CNT` = 0.
  - Strobes: `V0`, `V1`, `FRAME`, `ERR` = 0.
  - FSM state = `EXP0`.
- Data routing on an edge with `VALID`=1:
  - `S1`=0: `D0` <= `Y`, `V0`=1.
  - `S1`=1: `D1` <= `Y`, `V1`=1.
  - Routing happens regardless of FSM state. An out-of-order word is still captured.
- `VALID`=0: data registers hold, all strobes 0, FSM holds.
- FSM states and transitions:
  - `EXP0`, `S1`=0 -> `EXP1`.
  - `EXP0`, `S1`=1 -> `ERR`=1; stay `EXP0`.
  - `EXP1`, `S1`=1 -> `FRAME`=1; `FRAME_CNT`+1; go to `EXP0`.
  - `EXP1`, `S1`=0 -> `ERR`=1; stay `EXP1`. The new ch0 word restarts the frame.
- `FRAME_CNT` wraps from 2^CNT_W-1 to 0.
- `V0` and `V1` are never both 1 in the same cycle. `FRAME` coincides with `V1`. `ERR` coincides with exactly one of `V0`/`V1`.

## Timing
- Latency is 1 cycle: a word sampled at edge N appears on `D0`/`D1`, with its strobes, after edge N.
- Strobes are high for exactly one cycle per accepted word. Back-to-back `VALID` gives back-to-back strobes; there is no stall or backpressure.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset released mid-frame: the first word after release is judged from `EXP0`.
- A partially received frame is discarded by reset and not counted.

## Configuration
- With `DEMUX21_ERRCNT_EN` defined:
  - The `ERR_CNT` port and its register exist.
  - `ERR_CNT` increments on each `ERR` strobe and saturates at 2^CNT_W-1 (no wrap).
- Without it:
  - The `ERR_CNT` port and register are absent.
  - The `ERR` strobe is still produced.
  - All other behaviour is identical.

## Structure
- Shared package `demux21_pkg` holds:
  - FSM state encodings `EXP0`=1'b0 and `EXP1`=1'b1.
  - Channel select constants `CH0`=1'b0 and `CH1`=1'b1.
- One sub-module, `demux21_frame_fsm`, contains the FSM, `FRAME`/`ERR` generation, `FRAME_CNT`, and the optional `ERR_CNT`.
- The top level contains the routing registers and `V0`/`V1`.

## Test plan
- Reset check: assert `RST` mid-simulation with nonzero outputs -> all outputs 0 asynchronously, before the next edge.
- In-order frame: send `VALID`, `S1`=0, `Y`=8'h5A, then `S1`=1, `Y`=8'hA5 -> `D0`=5A with `V0`; `D1`=A5 with `V1` and `FRAME`; `FRAME_CNT`=1; `ERR`=0.
- Out-of-order:
  - From reset, send `S1`=1, `Y`=8'h11 -> `D1`=11, `V1`=1, `ERR`=1, `FRAME`=0.
  - Then send ch0 twice -> second ch0 gives `ERR`=1 and `D0` takes the newest value.
  - With the macro defined, `ERR_CNT`=2.
- Gaps: interleave `VALID`=0 cycles inside a frame -> outputs hold, strobes 0, and the frame completes normally.
- Wrap/saturate, with `CNT_W`=2:
  - 5 good frames -> `FRAME_CNT` sequence 1,2,3,0,1.
  - 5 errors -> `ERR_CNT` reaches 3 and stays there.
- Reset mid-frame: send ch0, pulse `RST`, then send ch1 -> `ERR`=1, `FRAME`=0, `FRAME_CNT`=0.

Source files
------------

// File: rtl/demux21_pkg.sv
// Shared definitions for the 1-to-2 TDM demultiplexer: frame-tracker states
// and channel-select encodings.
package demux21_pkg;

  typedef enum logic {
    EXP0 = 1'b0,
    EXP1 = 1'b1
  } frame_state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage : demux21_pkg

// File: rtl/demux21_frame_fsm.sv
// Frame tracker: enforces ch0-then-ch1 ordering, strobes FRAME/ERR and keeps
// the frame count. DEMUX21_ERRCNT_EN adds a saturating error counter.
module demux21_frame_fsm
  import demux21_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             sel_i,
  output logic             frame_o,
  output logic             err_o,
`ifdef DEMUX21_ERRCNT_EN
  output logic [CNT_W-1:0] err_cnt_o,
`endif
  output logic [CNT_W-1:0] frame_cnt_o
);

  frame_state_e     state_q, state_d;
  logic             frame_q, frame_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    frame_d     = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (valid_i) begin
      unique case (state_q)
        EXP0: begin
          if (sel_i == CH0) state_d = EXP1;
          else              err_d   = 1'b1;
        end
        EXP1: begin
          // A repeated ch0 word restarts the frame, so the state stays EXP1.
          if (sel_i == CH1) begin
            frame_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = EXP0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = EXP0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EXP0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_o     = frame_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;

`ifdef DEMUX21_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturates rather than wraps so a long-running error burst stays visible.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule : demux21_frame_fsm

// File: rtl/demux21_tdm.sv
// Registered 1-to-2 time-division demultiplexer with frame-order tracking.
// Define DEMUX21_ERRCNT_EN to expose the saturating ERR_CNT output.
module demux21_tdm
  import demux21_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALID,
  input  logic             S1,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic             V0,
  output logic             V1,
  output logic             FRAME,
  output logic [CNT_W-1:0] FRAME_CNT,
`ifdef DEMUX21_ERRCNT_EN
  output logic [CNT_W-1:0] ERR_CNT,
`endif
  output logic             ERR
);

  logic [WIDTH-1:0] d0_q, d0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic             v0_q, v0_d;
  logic             v1_q, v1_d;

  // Routing ignores frame state: out-of-order words are still captured.
  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    v0_d = 1'b0;
    v1_d = 1'b0;
    if (VALID) begin
      if (S1 == CH0) begin
        d0_d = Y;
        v0_d = 1'b1;
      end else begin
        d1_d = Y;
        v1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d0_q <= '0;
      d1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end

  assign D0 = d0_q;
  assign D1 = d1_q;
  assign V0 = v0_q;
  assign V1 = v1_q;

  demux21_frame_fsm #(
    .CNT_W(CNT_W)
  ) u_frame_fsm (
    .clk_i      (CLK),
    .rst_i      (RST),
    .valid_i    (VALID),
    .sel_i      (S1),
    .frame_o    (FRAME),
    .err_o      (ERR),
`ifdef DEMUX21_ERRCNT_EN
    .err_cnt_o  (ERR_CNT),
`endif
    .frame_cnt_o(FRAME_CNT)
  );

endmodule : demux21_tdm

// File: tb/tb_demux21_tdm.sv
// Directed self-checking bench for demux21_tdm (CNT_W=2 to reach wrap/saturation).
module tb_demux21_tdm;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             VALID = 1'b0;
  logic             S1 = 1'b0;
  logic [WIDTH-1:0] Y = '0;
  logic [WIDTH-1:0] D0, D1;
  logic             V0, V1, FRAME, ERR;
  logic [CNT_W-1:0] FRAME_CNT;
`ifdef DEMUX21_ERRCNT_EN
  logic [CNT_W-1:0] ERR_CNT;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  demux21_tdm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .VALID    (VALID),
    .S1       (S1),
    .Y        (Y),
    .D0       (D0),
    .D1       (D1),
    .V0       (V0),
    .V1       (V1),
    .FRAME    (FRAME),
    .FRAME_CNT(FRAME_CNT),
`ifdef DEMUX21_ERRCNT_EN
    .ERR_CNT  (ERR_CNT),
`endif
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                         input logic v0, input logic v1, input logic fr,
                         input logic er, input logic [1:0] fc);
    chk({tag, ".D0"}, 32'(D0), 32'(d0));
    chk({tag, ".D1"}, 32'(D1), 32'(d1));
    chk({tag, ".V0"}, 32'(V0), 32'(v0));
    chk({tag, ".V1"}, 32'(V1), 32'(v1));
    chk({tag, ".FRAME"}, 32'(FRAME), 32'(fr));
    chk({tag, ".ERR"}, 32'(ERR), 32'(er));
    chk({tag, ".FRAME_CNT"}, 32'(FRAME_CNT), 32'(fc));
    $display("[TB] %s D0=%h D1=%h V0=%b V1=%b FRAME=%b ERR=%b FRAME_CNT=%0d",
             tag, D0, D1, V0, V1, FRAME, ERR, FRAME_CNT);
  endtask

  task automatic chk_ecnt(input string tag, input logic [1:0] ec);
`ifdef DEMUX21_ERRCNT_EN
    chk({tag, ".ERR_CNT"}, 32'(ERR_CNT), 32'(ec));
`else
    if (ec > 2'd3) $display("[TB] %s unreachable", tag);
`endif
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic send(input logic v, input logic s, input logic [7:0] y);
    VALID = v;
    S1    = s;
    Y     = y;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    VALID = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    // Power-on reset
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk_all("por", 8'h00, 8'h00, 0, 0, 0, 0, 2'd0);
    chk_ecnt("por", 2'd0);
    RST = 1'b0;

    // In-order frame
    send(1, 0, 8'h5A);
    chk_all("ord0", 8'h5A, 8'h00, 1, 0, 0, 0, 2'd0);
    send(1, 1, 8'hA5);
    chk_all("ord1", 8'h5A, 8'hA5, 0, 1, 1, 0, 2'd1);

    // Asynchronous reset with nonzero outputs, checked before the next edge
    VALID = 1'b0;
    RST = 1'b1;
    #1;
    chk_all("arst", 8'h00, 8'h00, 0, 0, 0, 0, 2'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Out-of-order
    send(1, 1, 8'h11);
    chk_all("ooo_ch1", 8'h00, 8'h11, 0, 1, 0, 1, 2'd0);
    send(1, 0, 8'h22);
    chk_all("ooo_ch0a", 8'h22, 8'h11, 1, 0, 0, 0, 2'd0);
    send(1, 0, 8'h33);
    chk_all("ooo_ch0b", 8'h33, 8'h11, 1, 0, 0, 1, 2'd0);
    chk_ecnt("ooo", 2'd2);
    send(1, 1, 8'h44);
    chk_all("ooo_fin", 8'h33, 8'h44, 0, 1, 1, 0, 2'd1);

    // Gaps inside a frame
    send(1, 0, 8'h66);
    chk_all("gap_ch0", 8'h66, 8'h44, 1, 0, 0, 0, 2'd1);
    send(0, 1, 8'hFF);
    chk_all("gap_idle1", 8'h66, 8'h44, 0, 0, 0, 0, 2'd1);
    send(0, 0, 8'hEE);
    chk_all("gap_idle2", 8'h66, 8'h44, 0, 0, 0, 0, 2'd1);
    send(1, 1, 8'h77);
    chk_all("gap_ch1", 8'h66, 8'h77, 0, 1, 1, 0, 2'd2);

    // Frame counter wrap: 1,2,3,0,1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] a, b;
      logic [1:0] fc;
      a  = 8'(8'h10 + i);
      b  = 8'(8'h80 + i);
      fc = 2'(i + 1);
      send(1, 0, a);
      chk_all($sformatf("wrap%0d_ch0", i), a, (i == 0) ? 8'h00 : 8'(8'h80 + i - 1),
              1, 0, 0, 0, 2'(i));
      send(1, 1, b);
      chk_all($sformatf("wrap%0d_ch1", i), a, b, 0, 1, 1, 0, fc);
    end

    // Error counter saturation: five ch1 words from EXP0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      b = 8'(8'hC0 + i);
      send(1, 1, b);
      chk_all($sformatf("sat%0d", i), 8'h00, b, 0, 1, 0, 1, 2'd0);
      chk_ecnt($sformatf("sat%0d", i), (i < 3) ? 2'(i + 1) : 2'd3);
    end

    // Reset mid-frame discards the partial frame
    do_reset();
    send(1, 0, 8'h99);
    chk_all("mid_ch0", 8'h99, 8'h00, 1, 0, 0, 0, 2'd0);
    VALID = 1'b0;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    send(1, 1, 8'hAA);
    chk_all("mid_ch1", 8'h00, 8'hAA, 0, 1, 0, 1, 2'd0);
    chk_ecnt("mid", 2'd1);
    VALID = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_demux21_tdm
